sdram_arbit: RTL and testbench

- Central SDRAM command arbiter between the init, refresh, write and read engines.
- Owns the refresh interval timer and the auto-refresh sequence.
- Grants the bus to the write or read engine; both stall via ref_req and hand back with *_ref_break_end or *_data_end.
- Muxes the granted engine's 18-bit command word and write data onto the SDRAM pins.

---
 rtl/sdram_pkg.sv | 22 ++
 rtl/sdram_ref_timer.sv | 41 ++++
 rtl/sdram_arbit.sv | 127 ++++++++++++
 tb/tb_sdram_arbit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command constants and arbiter state encodings
package sdram_pkg;

    localparam int CMD_W = 18;

    // {cs_n, ras_n, cas_n, we_n, ba[1:0], addr[11:0]}
    localparam logic [CMD_W-1:0] NOP  = 18'h1C000;
    localparam logic [CMD_W-1:0] AREF = 18'h04000;
    localparam logic [CMD_W-1:0] PALL = 18'h08400;
    localparam logic [CMD_W-1:0] ACT  = 18'h0C000;
    localparam logic [CMD_W-1:0] WR   = 18'h10000;
    localparam logic [CMD_W-1:0] RD   = 18'h14000;

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_ARBIT = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } arb_state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// rtl/sdram_ref_timer.sv - refresh interval counter with pending request and overrun flag
module sdram_ref_timer #(
    parameter int REF_INTERVAL = 1500
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic ref_ack,
    output logic ref_req,
    output logic ref_overrun
);

    localparam int CW = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(REF_INTERVAL - 1);

    logic [CW-1:0] cnt;
    logic          expire;

    assign expire = run && (cnt == LAST);

    // The counter wraps independently of acknowledgement so the interval never drifts;
    // an expiry that lands on the acknowledging edge starts a fresh request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            ref_req     <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            if (!run || expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            ref_req <= expire | (ref_req & ~ref_ack);
            if (expire && ref_req && !ref_ack) begin
                ref_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command arbiter between init, refresh, write and read engines
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = 1500,
    parameter int T_RC         = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_end,
    input  logic [CMD_W-1:0] init_cmd,
    input  logic             w_req,
    input  logic [CMD_W-1:0] w_cmd,
    input  logic [15:0]      w_dq,
    input  logic             w_dq_oe,
    input  logic             write_data_end,
    input  logic             write_ref_break_end,
    input  logic             r_req,
    input  logic [CMD_W-1:0] r_cmd,
    input  logic             read_data_end,
    input  logic             read_ref_break_end,
    output logic             w_en,
    output logic             r_en,
    output logic             ref_req,
    output logic             ref_overrun,
    output logic [CMD_W-1:0] sd_cmd,
    output logic [15:0]      sd_dq_out,
    output logic             sd_dq_oe
);

    localparam int AW = (T_RC > 0) ? $clog2(T_RC + 1) : 1;
    localparam logic [AW-1:0] AREF_LAST = AW'(T_RC);

    arb_state_t    state;
    logic [AW-1:0] aref_cnt;
    logic          run;
    logic          ref_ack;

    assign run     = (state != ST_INIT);
    assign ref_ack = (state == ST_ARBIT) && ref_req;

    sdram_ref_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_ref_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .ref_ack    (ref_ack),
        .ref_req    (ref_req),
        .ref_overrun(ref_overrun)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            aref_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_end) begin
                        state <= ST_ARBIT;
                    end
                end
                ST_ARBIT: begin
                    aref_cnt <= '0;
                    if (ref_req) begin
                        state <= ST_AREF;
                    end else if (w_req) begin
                        state <= ST_WRITE;
                    end else if (r_req) begin
                        state <= ST_READ;
                    end
                end
                ST_AREF: begin
                    if (aref_cnt == AREF_LAST) begin
                        state    <= ST_ARBIT;
                        aref_cnt <= '0;
                    end else begin
                        aref_cnt <= aref_cnt + AW'(1);
                    end
                end
                ST_WRITE: begin
                    if (write_data_end || write_ref_break_end) begin
                        state <= ST_ARBIT;
                    end
                end
                ST_READ: begin
                    if (read_data_end || read_ref_break_end) begin
                        state <= ST_ARBIT;
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    aref_cnt <= '0;
                end
            endcase
        end
    end

    assign w_en = (state == ST_WRITE);
    assign r_en = (state == ST_READ);

    // Pins are held at NOP while rst is asserted so a reset cycle never forwards an engine command.
    always_comb begin
        sd_cmd    = NOP;
        sd_dq_out = '0;
        sd_dq_oe  = 1'b0;
        if (!rst) begin
            case (state)
                ST_INIT: sd_cmd = init_cmd;
                ST_AREF: begin
                    if (aref_cnt == '0) begin
                        sd_cmd = AREF;
                    end
                end
                ST_WRITE: begin
                    sd_cmd    = w_cmd;
                    sd_dq_out = w_dq;
                    sd_dq_oe  = w_dq_oe;
                end
                ST_READ: sd_cmd = r_cmd;
                default: sd_cmd = NOP;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - randomized self-checking bench for sdram_arbit against a behavioural model
module tb_sdram_arbit;

    localparam int RI  = 40;
    localparam int TRC = 7;
    localparam logic [17:0] E_NOP  = 18'h1C000;
    localparam logic [17:0] E_AREF = 18'h04000;

    logic        clk;
    logic        rst;
    logic        init_end;
    logic [17:0] init_cmd;
    logic        w_req;
    logic [17:0] w_cmd;
    logic [15:0] w_dq;
    logic        w_dq_oe;
    logic        write_data_end;
    logic        write_ref_break_end;
    logic        r_req;
    logic [17:0] r_cmd;
    logic        read_data_end;
    logic        read_ref_break_end;
    logic        w_en;
    logic        r_en;
    logic        ref_req;
    logic        ref_overrun;
    logic [17:0] sd_cmd;
    logic [15:0] sd_dq_out;
    logic        sd_dq_oe;

    sdram_arbit #(
        .REF_INTERVAL(RI),
        .T_RC        (TRC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .init_end           (init_end),
        .init_cmd           (init_cmd),
        .w_req              (w_req),
        .w_cmd              (w_cmd),
        .w_dq               (w_dq),
        .w_dq_oe            (w_dq_oe),
        .write_data_end     (write_data_end),
        .write_ref_break_end(write_ref_break_end),
        .r_req              (r_req),
        .r_cmd              (r_cmd),
        .read_data_end      (read_data_end),
        .read_ref_break_end (read_ref_break_end),
        .w_en               (w_en),
        .r_en               (r_en),
        .ref_req            (ref_req),
        .ref_overrun        (ref_overrun),
        .sd_cmd             (sd_cmd),
        .sd_dq_out          (sd_dq_out),
        .sd_dq_oe           (sd_dq_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: mode 0 powering up, 1 idle, 2 refreshing, 3 writing, 4 reading.
    int m_mode;
    int m_ticks;
    int m_aref_age;
    bit m_ref;
    bit m_ovr;

    task automatic model_reset();
        m_mode     = 0;
        m_ticks    = 0;
        m_aref_age = 0;
        m_ref      = 1'b0;
        m_ovr      = 1'b0;
    endtask

    task automatic model_edge();
        bit expire;
        bit ack;
        int nxt;
        if (rst) begin
            model_reset();
        end else begin
            expire = (m_mode != 0) && ((m_ticks % RI) == RI - 1);
            ack    = (m_mode == 1) && m_ref;
            nxt    = m_mode;
            case (m_mode)
                0: if (init_end) nxt = 1;
                1: begin
                    if (m_ref) nxt = 2;
                    else if (w_req) nxt = 3;
                    else if (r_req) nxt = 4;
                end
                2: if (m_aref_age == TRC) nxt = 1;
                3: if (write_data_end || write_ref_break_end) nxt = 1;
                4: if (read_data_end || read_ref_break_end) nxt = 1;
                default: nxt = 0;
            endcase
            m_aref_age = (m_mode == 2 && nxt == 2) ? m_aref_age + 1 : 0;
            m_ticks    = (m_mode != 0) ? m_ticks + 1 : 0;
            if (expire && m_ref && !ack) m_ovr = 1'b1;
            m_ref  = expire || (m_ref && !ack);
            m_mode = nxt;
        end
    endtask

    task automatic check_all();
        logic [17:0] e_cmd;
        bit          wr;
        wr = !rst && (m_mode == 3);
        if (rst) e_cmd = E_NOP;
        else case (m_mode)
            0: e_cmd = init_cmd;
            2: e_cmd = (m_aref_age == 0) ? E_AREF : E_NOP;
            3: e_cmd = w_cmd;
            4: e_cmd = r_cmd;
            default: e_cmd = E_NOP;
        endcase
        check_val("sd_cmd", 32'(sd_cmd), 32'(e_cmd));
        check_val("sd_dq_oe", 32'(sd_dq_oe), wr ? 32'(w_dq_oe) : 32'd0);
        check_val("sd_dq_out", 32'(sd_dq_out), wr ? 32'(w_dq) : 32'd0);
        check_val("w_en", 32'(w_en), 32'(m_mode == 3));
        check_val("r_en", 32'(r_en), 32'(m_mode == 4));
        check_val("ref_req", 32'(ref_req), 32'(m_ref));
        check_val("ref_overrun", 32'(ref_overrun), 32'(m_ovr));
    endtask

    task automatic cycle();
        #2;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_data();
        init_cmd = 18'($urandom);
        w_cmd    = 18'($urandom);
        r_cmd    = 18'($urandom);
        w_dq     = 16'($urandom);
        w_dq_oe  = 1'($urandom);
    endtask

    task automatic clear_ends();
        write_data_end      = 1'b0;
        write_ref_break_end = 1'b0;
        read_data_end       = 1'b0;
        read_ref_break_end  = 1'b0;
    endtask

    int n;

    initial begin
        rst = 1'b1; init_end = 1'b0; w_req = 1'b0; r_req = 1'b0;
        clear_ends();
        rand_data();
        @(posedge clk);
        #1;
        model_reset();
        repeat (2) begin rand_data(); cycle(); end
        check_val("rst_sd_cmd", 32'(sd_cmd), 32'(E_NOP));
        check_val("rst_ref_req", 32'(ref_req), 32'd0);

        // Power-up: init commands pass through, then refresh after one interval.
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin rand_data(); cycle(); end
        init_end = 1'b1; rand_data(); cycle(); init_end = 1'b0;
        n = 0;
        while (!ref_req && n < 100) begin rand_data(); cycle(); n++; end
        check_val("ref_latency", 32'(n), 32'(RI));
        cycle();
        check_val("aref_cmd", 32'(sd_cmd), 32'(E_AREF));
        for (int i = 0; i < TRC; i++) begin
            cycle();
            check_val("aref_nop", 32'(sd_cmd), 32'(E_NOP));
        end
        cycle();

        // Write wins over read; read follows after write ends.
        w_req = 1'b1; r_req = 1'b1; rand_data(); cycle();
        check_val("wr_grant_w", 32'(w_en), 32'd1);
        check_val("wr_grant_r", 32'(r_en), 32'd0);
        write_data_end = 1'b1; rand_data(); cycle();
        write_data_end = 1'b0; w_req = 1'b0; cycle();
        cycle();
        check_val("rd_grant", 32'(r_en), 32'd1);

        // Refresh rising during a read does not preempt it.
        n = 0;
        while (!ref_req && n < 100) begin rand_data(); cycle(); n++; end
        check_val("rd_ref_seen", 32'(ref_req), 32'd1);
        repeat (3) begin rand_data(); cycle(); end
        check_val("no_preempt", 32'(r_en), 32'd1);
        read_ref_break_end = 1'b1; cycle(); read_ref_break_end = 1'b0;
        cycle();
        check_val("break_aref", 32'(sd_cmd), 32'(E_AREF));
        repeat (TRC + 2) cycle();
        check_val("rd_regrant", 32'(r_en), 32'd1);
        r_req = 1'b0; read_data_end = 1'b1; cycle(); read_data_end = 1'b0;

        // Long write: stray read pulses are ignored and the refresh overruns.
        w_req = 1'b1;
        n = 0;
        while (!w_en && n < 50) begin rand_data(); cycle(); n++; end
        check_val("wr_wait", 32'(w_en), 32'd1);
        read_data_end = 1'b1; read_ref_break_end = 1'b1; cycle(); clear_ends();
        check_val("rd_end_ignored", 32'(w_en), 32'd1);
        repeat (2 * RI + 2) begin rand_data(); cycle(); end
        check_val("overrun_set", 32'(ref_overrun), 32'd1);
        write_data_end = 1'b1; write_ref_break_end = 1'b1; w_req = 1'b0; cycle();
        clear_ends();
        check_val("dual_end_w_en", 32'(w_en), 32'd0);
        repeat (TRC + 4) cycle();
        check_val("overrun_sticky", 32'(ref_overrun), 32'd1);

        // Reset in the middle of a refresh.
        n = 0;
        while (m_mode != 2 && n < 3 * RI) begin cycle(); n++; end
        check_val("aref_wait", 32'(m_mode == 2), 32'd1);
        cycle();
        rst = 1'b1; rand_data(); cycle();
        check_val("mid_rst_cmd", 32'(sd_cmd), 32'(E_NOP));
        check_val("mid_rst_w_en", 32'(w_en), 32'd0);
        check_val("mid_rst_r_en", 32'(r_en), 32'd0);
        check_val("mid_rst_ref", 32'(ref_req), 32'd0);
        check_val("mid_rst_ovr", 32'(ref_overrun), 32'd0);
        rst = 1'b0; init_end = 1'b1; cycle(); init_end = 1'b0;

        // Randomized traffic with stray end pulses and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            init_end = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) w_req = ~w_req;
            if ($urandom_range(0, 7) == 0) r_req = ~r_req;
            write_data_end      = ($urandom_range(0, 5) == 0);
            write_ref_break_end = ($urandom_range(0, 5) == 0);
            read_data_end       = ($urandom_range(0, 5) == 0);
            read_ref_break_end  = ($urandom_range(0, 5) == 0);
            rand_data();
            cycle();
        end
        rst = 1'b0;
        clear_ends();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
